fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TEXT_START, default 32'h0000_3000, the user-text reset PC.
REQ-002 SHALL have parameter KTEXT_START, default 32'h0000_4180, the exception handler entry PC.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port npc  input  32  next PC from the next-PC calculator for the current instr.
REQ-006 SHALL have port stall  input  1  hazard hold from the decode stage.
REQ-007 SHALL have port exc_req  input  1  take-exception request from the CP0/commit stage.
REQ-008 SHALL have port eret  input  1  return-from-exception request.
REQ-009 SHALL have port epc  input  32  return address used with eret.
REQ-010 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-011 SHALL have port imem_addr  output  32  fetch word address; always equals pc.
REQ-012 SHALL have port imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-013 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-014 SHALL have port pc  output  32  PC of the fetch in flight or of instr.
REQ-015 SHALL have port instr  output  32  fetched instruction presented to decode.
REQ-016 SHALL have port instr_valid  output  1  instr/pc pair is valid for decode.
REQ-017 SHALL have port adel  output  1  instr_valid carries a misaligned-fetch exception.
REQ-018 SHALL have port halted  output  1  controller is in HALT.

Function
REQ-019 SHALL implement states FETCH (request outstanding), HOLD (instr valid, held), HALT (end of text reached).
REQ-020 SHALL drive imem_req=1 only in FETCH with pc[1:0]==0; imem_req=0 in HOLD, HALT and during a misaligned pc.
REQ-021 SHALL, in FETCH on imem_ready, register instr<=imem_rdata, instr_valid<=1, and go to HOLD the next cycle (one-cycle minimum fetch latency; wait states extend FETCH indefinitely).
REQ-022 SHALL, in HOLD with stall=0, load pc<=npc, clear instr_valid and return to FETCH; with stall=1 keep pc, instr, instr_valid unchanged.
REQ-023 SHALL, in FETCH with pc[1:0]!=0, not request; next cycle present instr=32'h0, instr_valid=1, adel=1 and go to HOLD; adel SHALL clear when instr_valid clears.
REQ-024 SHALL enter HALT when advancing to pc==KTEXT_START-4: pc holds that value, imem_req=0, instr_valid=0, halted=1; only reset or exc_req leave HALT.
REQ-025 SHALL, on exc_req=1 in any state, load pc<=KTEXT_START, clear instr_valid and adel, discard any same-cycle imem_rdata, and go to FETCH.
REQ-026 SHALL, on eret=1 (exc_req=0) in FETCH or HOLD, load pc<=epc, clear instr_valid, discard same-cycle imem_rdata, and go to FETCH; eret in HALT is ignored.
REQ-027 SHALL apply priority reset > exc_req > eret > HALT entry > stall > normal advance.
REQ-028 SHALL ignore stall in FETCH (no instruction is held yet).
REQ-029 SHALL treat all PC arithmetic as 32-bit unsigned; no range check beyond alignment and the HALT address.

Reset
REQ-030 SHALL, while reset=1 at a rising edge, set pc=TEXT_START, state=FETCH, instr=0, instr_valid=0, adel=0, halted=0; imem_req asserts in the first cycle after reset.
REQ-031 SHALL abandon any outstanding fetch on reset mid-operation; a coincident imem_ready is ignored.

Verification
REQ-032 Reset, imem_ready=1 every cycle, npc=pc+4, stall=0 -> pc 0x3000, 0x3004, 0x3008 with instr_valid toggling 1 every other cycle, instr matching memory.
REQ-033 Fetch at 0x3000 with imem_ready after 3 wait cycles, stall=1 for 2 cycles in HOLD -> imem_req high 4 cycles, instr/pc stable through stall, pc becomes npc the cycle after stall drops.
REQ-034 exc_req in same cycle as imem_ready at pc 0x3010 -> instr_valid stays 0, pc=0x4180 next cycle, imem_req=1; then eret with epc=0x3014 -> pc=0x3014, FETCH.
REQ-035 npc=0x0000_417C -> halted=1, imem_req=0, pc stays 0x417C over 10 cycles; eret ignored; exc_req -> pc=0x4180, halted=0.
REQ-036 npc=0x3002 -> no imem_req, next cycle instr=0, instr_valid=1, adel=1; exc_req -> adel=0, pc=0x4180.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Fetch-controller bus bundle: next-PC/exception controls, the
//            instruction-memory handshake and the decode-side outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic [31:0] npc;
    logic        stall;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        adel;
    logic        halted;

    modport master (
        input  npc, stall, exc_req, eret, epc, imem_ready, imem_rdata,
        output imem_req, imem_addr, pc, instr, instr_valid, adel, halted
    );

    modport slave (
        output npc, stall, exc_req, eret, epc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, pc, instr, instr_valid, adel, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction fetch controller with FETCH/HOLD/HALT sequencing,
//            misaligned-fetch trapping and exception/eret redirection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] TEXT_START  = 32'h0000_3000,
    parameter logic [31:0] KTEXT_START = 32'h0000_4180
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_ctrl_if.master  bus
);

    localparam logic [1:0]  c_st_fetch = 2'd0;
    localparam logic [1:0]  c_st_hold  = 2'd1;
    localparam logic [1:0]  c_st_halt  = 2'd2;
    localparam logic [31:0] c_halt_pc  = KTEXT_START - 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_adel;
    logic        w_misaligned;
    logic        w_halt_entry;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_halt_entry = (bus.npc == c_halt_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Halt entry outranks stall, so a held instruction whose successor is the
    // end-of-text address still parks the controller.
    always_comb begin
        w_next_state = r_state;
        if (bus.exc_req) begin
            w_next_state = c_st_fetch;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (bus.eret)
                        w_next_state = c_st_fetch;
                    else if (w_misaligned || bus.imem_ready)
                        w_next_state = c_st_hold;
                end
                c_st_hold: begin
                    if (bus.eret)
                        w_next_state = c_st_fetch;
                    else if (w_halt_entry)
                        w_next_state = c_st_halt;
                    else if (!bus.stall)
                        w_next_state = c_st_fetch;
                end
                c_st_halt: w_next_state = c_st_halt;
                default:   w_next_state = c_st_fetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= TEXT_START;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else if (bus.exc_req) begin
            r_pc    <= KTEXT_START;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (bus.eret) begin
                        r_pc    <= bus.epc;
                        r_valid <= 1'b0;
                        r_adel  <= 1'b0;
                    end else if (w_misaligned) begin
                        r_instr <= 32'h0;
                        r_valid <= 1'b1;
                        r_adel  <= 1'b1;
                    end else if (bus.imem_ready) begin
                        r_instr <= bus.imem_rdata;
                        r_valid <= 1'b1;
                    end
                end
                c_st_hold: begin
                    if (bus.eret) begin
                        r_pc    <= bus.epc;
                        r_valid <= 1'b0;
                        r_adel  <= 1'b0;
                    end else if (w_halt_entry || !bus.stall) begin
                        r_pc    <= bus.npc;
                        r_valid <= 1'b0;
                        r_adel  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_req    = (r_state == c_st_fetch) && !w_misaligned;
        bus.halted      = (r_state == c_st_halt);
        bus.imem_addr   = r_pc;
        bus.pc          = r_pc;
        bus.instr       = r_instr;
        bus.instr_valid = r_valid;
        bus.adel        = r_adel;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl: directed scenarios plus
//            randomized stimulus scored against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_text  = 32'h0000_3000;
    localparam logic [31:0] c_ktext = 32'h0000_4180;
    localparam logic [31:0] c_halt  = 32'h0000_417C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .TEXT_START  (c_text),
        .KTEXT_START (c_ktext)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: "fetching" is neither holding a valid instruction nor halted.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_adel;
    logic        m_halted;

    function automatic logic [99:0] exp_vec();
        logic req;
        req = !m_valid && !m_halted && (m_pc[1:0] == 2'b00);
        return {req, m_pc, m_pc, (m_valid ? m_instr : 32'h0), m_valid, m_adel, m_halted};
    endfunction

    logic [99:0] obs_vec;
    assign obs_vec = {bus.imem_req, bus.imem_addr, bus.pc,
                      (bus.instr_valid ? bus.instr : 32'h0),
                      bus.instr_valid, bus.adel, bus.halted};

    function automatic void model_update();
        if (reset) begin
            m_pc = c_text; m_instr = 32'h0; m_valid = 1'b0; m_adel = 1'b0; m_halted = 1'b0;
        end else if (bus.exc_req) begin
            m_pc = c_ktext; m_valid = 1'b0; m_adel = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // only reset or an exception leaves the halted condition
        end else if (bus.eret) begin
            m_pc = bus.epc; m_valid = 1'b0; m_adel = 1'b0;
        end else if (m_valid) begin
            if (bus.npc == c_halt) begin
                m_pc = bus.npc; m_valid = 1'b0; m_adel = 1'b0; m_halted = 1'b1;
            end else if (!bus.stall) begin
                m_pc = bus.npc; m_valid = 1'b0; m_adel = 1'b0;
            end
        end else if (m_pc[1:0] != 2'b00) begin
            m_instr = 32'h0; m_valid = 1'b1; m_adel = 1'b1;
        end else if (bus.imem_ready) begin
            m_instr = bus.imem_rdata; m_valid = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.npc        = m_pc + 32'd4;
        bus.stall      = 1'b0;
        bus.exc_req    = 1'b0;
        bus.eret       = 1'b0;
        bus.epc        = c_text;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.npc = c_text; bus.stall = 1'b0; bus.exc_req = 1'b0; bus.eret = 1'b0;
        bus.epc = c_text; bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        tick();
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.pc !== c_text || bus.instr !== 32'h0 || bus.instr_valid !== 1'b0 ||
            bus.adel !== 1'b0 || bus.halted !== 1'b0 || bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state pc=%h instr=%h v=%b adel=%b halt=%b req=%b want pc=%h instr=0 v=0 adel=0 halt=0 req=1",
                     bus.pc, bus.instr, bus.instr_valid, bus.adel, bus.halted, bus.imem_req, c_text);
        end
        // reset with a coincident imem_ready must drop the returning word
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
        tick();
        reset = 1'b0; idle_inputs();
        n_total++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== c_text) begin
            n_bad++;
            $display("FAIL reset_midfetch v=%b pc=%h want v=0 pc=%h", bus.instr_valid, bus.pc, c_text);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = 1'b1;
            bus.imem_rdata = $urandom;
            bus.npc        = m_pc + 32'd4;
            tick();
            n_total++;
            if (obs_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL seq[%0d] dut=%h model=%h", i, obs_vec, exp_vec());
            end
            n_total++;
            if (bus.instr_valid !== ((i % 2) == 0)) begin
                n_bad++;
                $display("FAIL seq_valid[%0d] got=%b want=%b", i, bus.instr_valid, (i % 2) == 0);
            end
        end
        n_total++;
        if (bus.pc !== 32'h0000_3008) begin
            n_bad++;
            $display("FAIL seq_pc got=%h want=%h", bus.pc, 32'h0000_3008);
        end
    endtask

    task automatic test_wait_stall();
        logic [31:0] d;
        int          req_cycles;
        d = $urandom;
        req_cycles = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (bus.imem_req === 1'b1) req_cycles++;
            bus.imem_ready = (i == 3);
            bus.imem_rdata = (i == 3) ? d : 32'h0BAD_0000;
            tick();
        end
        bus.imem_ready = 1'b0;
        n_total++;
        if (req_cycles != 4) begin
            n_bad++;
            $display("FAIL wait_req_cycles got=%0d want=4", req_cycles);
        end
        bus.stall = 1'b1; bus.npc = 32'h0000_3040;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.pc !== c_text || bus.imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d] v=%b instr=%h pc=%h req=%b want v=1 instr=%h pc=%h req=0",
                         i, bus.instr_valid, bus.instr, bus.pc, bus.imem_req, d, c_text);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_total++;
        if (bus.pc !== 32'h0000_3040 || bus.instr_valid !== 1'b0 || obs_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL stall_release pc=%h v=%b want pc=00003040 v=0", bus.pc, bus.instr_valid);
        end
    endtask

    task automatic test_exc_eret();
        do_reset();
        bus.eret = 1'b1; bus.epc = 32'h0000_3010;
        tick();
        bus.eret = 1'b0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.exc_req = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== c_ktext || bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL exc_discard v=%b pc=%h req=%b want v=0 pc=%h req=1",
                     bus.instr_valid, bus.pc, bus.imem_req, c_ktext);
        end
        bus.eret = 1'b1; bus.epc = 32'h0000_3014;
        tick();
        idle_inputs();
        n_total++;
        if (bus.pc !== 32'h0000_3014 || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL eret_return pc=%h req=%b v=%b want pc=00003014 req=1 v=0",
                     bus.pc, bus.imem_req, bus.instr_valid);
        end
    endtask

    task automatic test_halt();
        do_reset();
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
        tick();
        bus.imem_ready = 1'b0; bus.npc = c_halt;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== c_halt || bus.instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_hold[%0d] halt=%b req=%b pc=%h v=%b want halt=1 req=0 pc=%h v=0",
                         i, bus.halted, bus.imem_req, bus.pc, bus.instr_valid, c_halt);
            end
            bus.eret       = (i % 3) == 0;
            bus.epc        = 32'h0000_3000;
            bus.stall      = 1'($urandom_range(0, 1));
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.npc        = $urandom;
            tick();
        end
        idle_inputs();
        bus.exc_req = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (bus.pc !== c_ktext || bus.halted !== 1'b0 || bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_exit pc=%h halt=%b req=%b want pc=%h halt=0 req=1",
                     bus.pc, bus.halted, bus.imem_req, c_ktext);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hAAAA_5555;
        tick();
        bus.imem_ready = 1'b0; bus.npc = 32'h0000_3002;
        tick();
        n_total++;
        if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0000_3002) begin
            n_bad++;
            $display("FAIL misalign_noreq req=%b pc=%h want req=0 pc=00003002", bus.imem_req, bus.pc);
        end
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        n_total++;
        if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b1 || bus.adel !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_adel instr=%h v=%b adel=%b want instr=0 v=1 adel=1",
                     bus.instr, bus.instr_valid, bus.adel);
        end
        bus.exc_req = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (bus.adel !== 1'b0 || bus.pc !== c_ktext || bus.instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_exc adel=%b pc=%h v=%b want adel=0 pc=%h v=0",
                     bus.adel, bus.pc, bus.instr_valid, c_ktext);
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            bus.exc_req    = ($urandom_range(0, 29) == 0);
            bus.eret       = ($urandom_range(0, 24) == 0);
            bus.stall      = ($urandom_range(0, 2) == 0);
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            bus.epc        = c_text + (32'($urandom_range(0, 255)) << 2);
            k = $urandom_range(0, 19);
            if (k == 0)      bus.npc = m_pc + 32'd2;
            else if (k == 1) bus.npc = c_halt;
            else             bus.npc = m_pc + 32'd4;
            tick();
            n_total++;
            if (obs_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand[%0d] dut=%h model=%h", i, obs_vec, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        m_pc = c_text; m_instr = 32'h0; m_valid = 1'b0; m_adel = 1'b0; m_halted = 1'b0;
        test_reset();
        test_sequential();
        test_wait_stall();
        test_exc_eret();
        test_halt();
        test_misaligned();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
